// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment type, active-high hex glyphs {g,f,e,d,c,b,a} and decode helper
package seg7_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_0 = 7'h3F;
  localparam seg7_t SEG_1 = 7'h06;
  localparam seg7_t SEG_2 = 7'h5B;
  localparam seg7_t SEG_3 = 7'h4F;
  localparam seg7_t SEG_4 = 7'h66;
  localparam seg7_t SEG_5 = 7'h6D;
  localparam seg7_t SEG_6 = 7'h7D;
  localparam seg7_t SEG_7 = 7'h07;
  localparam seg7_t SEG_8 = 7'h7F;
  localparam seg7_t SEG_9 = 7'h6F;
  localparam seg7_t SEG_A = 7'h77;
  localparam seg7_t SEG_B = 7'h7C;
  localparam seg7_t SEG_C = 7'h39;
  localparam seg7_t SEG_D = 7'h5E;
  localparam seg7_t SEG_E = 7'h79;
  localparam seg7_t SEG_F = 7'h71;
  localparam seg7_t SEG_OFF = 7'h00;
  function automatic seg7_t hex2seg(input logic [3:0] h);
    hex2seg = SEG_OFF;
    case (h)
      4'h0: hex2seg = SEG_0;
      4'h1: hex2seg = SEG_1;
      4'h2: hex2seg = SEG_2;
      4'h3: hex2seg = SEG_3;
      4'h4: hex2seg = SEG_4;
      4'h5: hex2seg = SEG_5;
      4'h6: hex2seg = SEG_6;
      4'h7: hex2seg = SEG_7;
      4'h8: hex2seg = SEG_8;
      4'h9: hex2seg = SEG_9;
      4'hA: hex2seg = SEG_A;
      4'hB: hex2seg = SEG_B;
      4'hC: hex2seg = SEG_C;
      4'hD: hex2seg = SEG_D;
      4'hE: hex2seg = SEG_E;
      4'hF: hex2seg = SEG_F;
    endcase
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit-word load side and pin side of the display scan driver
interface seg7_scan_driver_if
  import seg7_pkg::*;
  #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0] dp_in, blank_in, blink_in;
  logic lzs_en, load;
  seg7_t seg_out;
  logic dp_out;
  logic [NUM_DIGITS-1:0] an_out;
  logic frame_done;
  modport master (output digits_in, dp_in, blank_in, blink_in, lzs_en, load,
                  input seg_out, dp_out, an_out, frame_done);
  modport slave (input digits_in, dp_in, blank_in, blink_in, lzs_en, load,
                 output seg_out, dp_out, an_out, frame_done);
endinterface

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational nibble to active-high segment pattern
module seg7_hex_dec
  import seg7_pkg::*;
  (
  input logic [3:0] nib,
  output seg7_t seg
);
  assign seg = hex2seg(nib);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with frame-synchronous shadow, blink, blank and LZS
module seg7_scan_driver
  import seg7_pkg::*;
  #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD = 16,
  parameter int BLINK_FRAMES = 60,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW = 1'b1
) (
  input logic clk,
  input logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int SW = 7 * NUM_DIGITS + 1;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [BW-1:0] blinkCnt;
  logic blinkOff, pendVld, lzs, slotEnd, frameEnd, blinkWrap, anOn, showDp;
  logic [SW-1:0] active, pending, inWord;
  logic [4*NUM_DIGITS-1:0] dig;
  logic [NUM_DIGITS-1:0] dp, blank, blink, dark, anQ;
  seg7_t decSeg, segQ;
  logic dpQ, frameQ;
  assign inWord = {bus.lzs_en, bus.blink_in, bus.blank_in, bus.dp_in, bus.digits_in};
  assign {lzs, blink, blank, dp, dig} = active;
  assign slotEnd = pre == PW'(SCAN_DIV - 1);
  assign frameEnd = slotEnd && idx == IW'(NUM_DIGITS - 1);
  assign blinkWrap = blinkCnt == BW'(BLINK_FRAMES - 1);
  assign anOn = pre >= PW'(GUARD);
  // a digit is zero-suppressed when it and every more significant digit are zero
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dark
    assign dark[k] = blank[k] | (blink[k] & blinkOff) | (lzs && k != 0 && (dig >> (4 * k)) == '0);
  end
  assign showDp = dp[idx] & ~blank[idx] & ~(blink[idx] & blinkOff);
  seg7_hex_dec u_dec (.nib(dig[4*idx +: 4]), .seg(decSeg));
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      blinkCnt <= '0;
      blinkOff <= 1'b0;
      active <= '0;
      pending <= '0;
      pendVld <= 1'b0;
    end else begin
      pre <= slotEnd ? '0 : pre + 1'b1;
      if (slotEnd) idx <= frameEnd ? '0 : idx + 1'b1;
      if (frameEnd) blinkCnt <= blinkWrap ? '0 : blinkCnt + 1'b1;
      if (frameEnd && blinkWrap) blinkOff <= ~blinkOff;
      if (bus.load) pending <= inWord;
      if (frameEnd && pendVld) active <= pending;
      pendVld <= bus.load ? 1'b1 : (frameEnd ? 1'b0 : pendVld);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      anQ <= {NUM_DIGITS{AN_ACT_LOW}};
      segQ <= {7{SEG_ACT_LOW}};
      dpQ <= SEG_ACT_LOW;
      frameQ <= 1'b0;
    end else begin
      anQ <= (anOn ? NUM_DIGITS'(1) << idx : '0) ^ {NUM_DIGITS{AN_ACT_LOW}};
      segQ <= (anOn && !dark[idx] ? decSeg : SEG_OFF) ^ {7{SEG_ACT_LOW}};
      dpQ <= (anOn && showDp) ^ SEG_ACT_LOW;
      frameQ <= frameEnd;
    end
  end
  assign bus.an_out = anQ;
  assign bus.seg_out = segQ;
  assign bus.dp_out = dpQ;
  assign bus.frame_done = frameQ;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed checks against a time-indexed display model
module tb_seg7_scan_driver;
  typedef struct packed {
    logic [15:0] dig;
    logic [3:0] dp, blank, blink;
    logic lzs;
  } shadow_t;
  localparam logic [12:0] RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0};
  logic clk = 1'b0, rst = 1'b1;
  int compared = 0, mismatched = 0, cnt = 0;
  bit inRst = 1'b1;
  int loadAt[$];
  shadow_t loadVal[$];
  logic [6:0] tbl[16];
  logic [12:0] exp;
  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus();
  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2), .BLINK_FRAMES(2),
                     .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // cnt = number of clean cycles since reset; every load is logged with the cycle it was taken on
  always @(posedge clk) begin
    if (rst) begin
      cnt = 0;
      loadAt.delete();
      loadVal.delete();
    end else begin
      if (bus.load) begin
        loadAt.push_back(cnt);
        loadVal.push_back({bus.digits_in, bus.dp_in, bus.blank_in, bus.blink_in, bus.lzs_en});
      end
      cnt++;
    end
    inRst = rst;
  end
  function automatic logic [6:0] segs(string s);
    logic [6:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction
  function automatic shadow_t mk(logic [15:0] d, logic [3:0] p, logic [3:0] bl, logic [3:0] bk, logic z);
    return {d, p, bl, bk, z};
  endfunction
  // expected pins after the edge that left cycle c: frame f shows the last load taken before its opening boundary
  function automatic logic [12:0] model(int c);
    shadow_t s = '0;
    int f = c / 32;
    int slot = (c % 32) / 8;
    bit off = (f / 2) % 2 == 1;
    bit on = (c % 8) >= 2;
    bit dark;
    logic [3:0] an;
    logic [6:0] sg;
    logic dpv;
    foreach (loadAt[i]) if (loadAt[i] <= 32 * f - 2) s = loadVal[i];
    dark = s.blank[slot] || (s.blink[slot] && off) || (s.lzs && slot > 0 && (s.dig >> (4 * slot)) == 0);
    an = on ? ~(4'b1 << slot) : 4'hF;
    sg = (on && !dark) ? ~tbl[s.dig[slot*4 +: 4]] : 7'h7F;
    dpv = !(on && s.dp[slot] && !s.blank[slot] && !(s.blink[slot] && off));
    return {an, sg, dpv, c % 32 == 31};
  endfunction
  function automatic logic [12:0] got();
    return {bus.an_out, bus.seg_out, bus.dp_out, bus.frame_done};
  endfunction
  task automatic drive(shadow_t s, bit ld);
    {bus.digits_in, bus.dp_in, bus.blank_in, bus.blink_in, bus.lzs_en} = s;
    bus.load = ld;
  endtask
  task automatic test_reset();
    drive('0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      exp = inRst ? RST_OUT : model(cnt - 1);
      compared++;
      if (got() !== exp) begin
        mismatched++;
        $display("FAIL reset i=%0d got=%h exp=%h", i, got(), exp);
      end
      rst = (i < 2) || (i >= 15 && i < 18);
    end
  endtask
  task automatic test_scan();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      exp = inRst ? RST_OUT : model(cnt - 1);
      compared++;
      if (got() !== exp) begin
        mismatched++;
        $display("FAIL scan i=%0d got=%h exp=%h", i, got(), exp);
      end
      drive(mk(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0), i == 0);
    end
  endtask
  task automatic test_no_tearing();
    for (int i = 0; i < 130; i++) begin
      @(posedge clk); #1;
      exp = inRst ? RST_OUT : model(cnt - 1);
      compared++;
      if (got() !== exp) begin
        mismatched++;
        $display("FAIL no_tearing i=%0d got=%h exp=%h", i, got(), exp);
      end
      if (i == 0) drive(mk(16'h1234, 4'h2, 4'h0, 4'h0, 1'b0), 1'b1);
      else if (i == 45) drive(mk(16'h5678, 4'h1, 4'h0, 4'h0, 1'b0), 1'b1);
      else bus.load = 1'b0;
    end
  endtask
  task automatic test_lzs();
    for (int i = 0; i < 140; i++) begin
      @(posedge clk); #1;
      exp = inRst ? RST_OUT : model(cnt - 1);
      compared++;
      if (got() !== exp) begin
        mismatched++;
        $display("FAIL lzs i=%0d got=%h exp=%h", i, got(), exp);
      end
      if (i == 0) drive(mk(16'h0050, 4'hC, 4'h0, 4'h0, 1'b1), 1'b1);
      else if (i == 40) drive(mk(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1), 1'b1);
      else if (i == 80) drive(mk(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0), 1'b1);
      else bus.load = 1'b0;
    end
  endtask
  task automatic test_blink_blank();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      exp = inRst ? RST_OUT : model(cnt - 1);
      compared++;
      if (got() !== exp) begin
        mismatched++;
        $display("FAIL blink_blank i=%0d got=%h exp=%h", i, got(), exp);
      end
      drive(mk(16'h8765, 4'b1001, 4'b1000, 4'b0011, 1'b0), i == 0);
    end
  endtask
  task automatic test_hex();
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      exp = inRst ? RST_OUT : model(cnt - 1);
      compared++;
      if (got() !== exp) begin
        mismatched++;
        $display("FAIL hex i=%0d got=%h exp=%h", i, got(), exp);
      end
      if (i == 0) drive(mk(16'hFEDC, 4'h0, 4'h0, 4'h0, 1'b0), 1'b1);
      else if (i == 40) drive(mk(16'hBA98, 4'h0, 4'h0, 4'h0, 1'b0), 1'b1);
      else bus.load = 1'b0;
    end
  endtask
  task automatic test_random();
    shadow_t r;
    for (int i = 0; i < 420; i++) begin
      @(posedge clk); #1;
      exp = inRst ? RST_OUT : model(cnt - 1);
      compared++;
      if (got() !== exp) begin
        mismatched++;
        $display("FAIL random i=%0d got=%h exp=%h", i, got(), exp);
      end
      r = shadow_t'(29'($urandom));
      drive(r, (cnt % 32 == 31 && $urandom_range(1) == 1) || $urandom_range(7) == 0);
      rst = i >= 250 && i < 253;
    end
    bus.load = 1'b0;
  endtask
  initial begin
    tbl[0] = segs("abcdef"); tbl[1] = segs("bc");     tbl[2] = segs("abdeg");  tbl[3] = segs("abcdg");
    tbl[4] = segs("bcfg");   tbl[5] = segs("acdfg");  tbl[6] = segs("acdefg"); tbl[7] = segs("abc");
    tbl[8] = segs("abcdefg"); tbl[9] = segs("abcdfg"); tbl[10] = segs("abcefg"); tbl[11] = segs("cdefg");
    tbl[12] = segs("adef");  tbl[13] = segs("bcdeg"); tbl[14] = segs("adefg"); tbl[15] = segs("aefg");
    test_reset();
    test_scan();
    test_no_tearing();
    test_lzs();
    test_blink_blank();
    test_hex();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
